pipe_stall_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage pipeline.
- Drives the enable/clear inputs of the PC, F/D, D/E, E/M and M/W registers.
  - E/M and M/W are the register blocks with clk/reset/en ports.
- Detects read-after-write hazards from Tuse/Tnew.
- Sequences the multi-cycle mult/div unit with a busy countdown, and holds D while the MDU is occupied.

---
 rtl/pipe_stall_ctrl.sv | 96 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall controller for the 5-stage pipeline.
// Detects RAW hazards from Tuse/Tnew and sequences the multi-cycle MDU.
// Optional macro STALL_CNT_EN adds a free-running 32-bit stall counter.
module pipe_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        en_pc,
    output logic        en_fd,
    output logic        clr_de,
    output logic        en_em,
    output logic        en_mw,
    output logic        md_busy,
    output logic        stall
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [3:0] md_cnt;
    logic       busy_raw;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       stall_raw;

    // Busy countdown: a start is only accepted when the MDU is idle.
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= 4'd0;
        else if (e_md_start && (md_cnt == 4'd0))
            md_cnt <= e_md_div ? DIV_LD : MULT_LD;
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

    assign busy_raw = (md_cnt != 4'd0);

    // RAW hazard: the producer's result arrives later than D needs it; $0 and Tnew=0 never stall.
    always_comb begin
        stall_rs = (d_rs != 5'd0) &&
                   (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                    ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
        stall_rt = (d_rt != 5'd0) &&
                   (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                    ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
        stall_md = d_is_md && (busy_raw || e_md_start);
        stall_raw = stall_rs | stall_rt | stall_md;
    end

    // Register controls: hold PC/FD and bubble D/E on stall; E/M and M/W always drain.
    always_comb begin
        en_pc   = 1'b1;
        en_fd   = 1'b1;
        clr_de  = 1'b0;
        en_em   = 1'b1;
        en_mw   = 1'b1;
        md_busy = 1'b0;
        stall   = 1'b0;
        if (!reset) begin
            md_busy = busy_raw;
            stall   = stall_raw;
            en_pc   = ~stall_raw;
            en_fd   = ~stall_raw;
            clr_de  = stall_raw;
        end
    end

`ifdef STALL_CNT_EN
    // Count stalled cycles; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 32'd0;
        else if (stall_raw)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: directed vectors, scoreboard queue of
// expected per-cycle outputs, checked by an independent negedge monitor.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, e_md_start, e_md_div;
    logic        en_pc, en_fd, clr_de, en_em, en_mw, md_busy, stall;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct packed {
        logic stall;
        logic en_pc;
        logic en_fd;
        logic clr_de;
        logic en_em;
        logic en_mw;
        logic md_busy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_is_md(d_is_md), .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .en_pc(en_pc), .en_fd(en_fd), .clr_de(clr_de), .en_em(en_em), .en_mw(en_mw),
        .md_busy(md_busy), .stall(stall)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Monitor: every cycle with a queued expectation, compare all outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb.pop_front();
            a = '{stall, en_pc, en_fd, clr_de, en_em, en_mw, md_busy};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle%0d outputs{stall,pc,fd,clr,em,mw,busy}: got %b expected %b",
                         cyc_no, a, e);
            end
            cyc_no++;
        end
    end

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input logic s, input logic b);
        sb.push_back('{s, ~s, ~s, s, 1'b1, 1'b1, b});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hz();
        d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
        e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
    endtask

    initial begin
        reset = 1; d_is_md = 0; e_md_start = 0; e_md_div = 0;
        clear_hz();
        @(posedge clk); #1;

        // Reset forces idle outputs even with a live hazard and md start
        d_rs = 5; d_tuse_rs = 0; e_wa = 5; e_tnew = 2; d_is_md = 1; e_md_start = 1;
        step(0, 0);
        // Load-use from E
        reset = 0; d_is_md = 0; e_md_start = 0;
        step(1, 0);
        // Producer moved to M, Tuse caught up: no stall
        e_wa = 0; e_tnew = 0; m_wa = 5; m_tnew = 1; d_tuse_rs = 1;
        step(0, 0);
        // Register 0 never stalls
        d_rs = 0; e_wa = 0; e_tnew = 2; d_tuse_rs = 0; m_wa = 0; m_tnew = 0;
        step(0, 0);
        // Tnew = 0 never stalls
        d_rs = 5; e_wa = 5; e_tnew = 0;
        step(0, 0);
        // rt hazard from M
        clear_hz(); d_rt = 7; d_tuse_rt = 0; m_wa = 7; m_tnew = 1;
        step(1, 0);
        // E and M same reg: only M condition true
        d_rt = 9; d_tuse_rt = 1; e_wa = 9; e_tnew = 1; m_wa = 9; m_tnew = 2;
        step(1, 0);
        clear_hz();
        step(0, 0);

        // Mult: stall on start cycle plus 5 busy cycles
        d_is_md = 1; e_md_start = 1; e_md_div = 0;
        step(1, 0);
        e_md_start = 0;
        for (int i = 0; i < 5; i++) step(1, 1);
        step(0, 0);

        // Div: busy exactly 10 cycles, restart at busy cycle 3 ignored
        d_is_md = 0; e_md_start = 1; e_md_div = 1;
        step(0, 0);
        for (int i = 1; i <= 10; i++) begin
            e_md_start = (i == 3);
            step(0, 1);
        end
        e_md_start = 0;
        step(0, 0);

        // Reset in busy cycle 4 of a div
        e_md_start = 1; e_md_div = 1;
        step(0, 0);
        e_md_start = 0; d_is_md = 1;
        for (int i = 0; i < 3; i++) step(1, 1);
        reset = 1;
        step(0, 0);
        reset = 0;
        step(0, 0);
        d_is_md = 0;
        step(0, 0);

`ifdef STALL_CNT_EN
        reset = 1;
        step(0, 0);
        reset = 0;
        d_rs = 5; d_tuse_rs = 0; e_wa = 5; e_tnew = 2;
        for (int i = 0; i < 3; i++) step(1, 0);
        clear_hz();
        e_md_start = 1; e_md_div = 0;
        step(0, 0);
        e_md_start = 0; d_is_md = 1;
        for (int i = 0; i < 5; i++) step(1, 1);
        d_is_md = 0;
        step(0, 0);
        n_tests++;
        if (stall_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL stall_cnt_after_8: got %0d expected 8", stall_cnt);
        end
        reset = 1;
        step(0, 0);
        reset = 0;
        n_tests++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_cnt_after_reset: got %0d expected 0", stall_cnt);
        end
`endif

        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
